fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_W, default 8: program-counter and instruction-memory address width.
REQ-002 SHALL have parameter INSTR_W, default 16: instruction width; opcode = instruction[INSTR_W-1:INSTR_W-4].
REQ-003 SHALL have i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have i_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have i_stall  input  1  hold PC, in-flight request and IF/ID register.
REQ-006 SHALL have i_branch_taken  input  1  redirect request from execute stage.
REQ-007 SHALL have i_branch_target  input  PC_W  redirect address.
REQ-008 SHALL have o_imem_addr  output  PC_W  instruction-memory read address, driven combinationally from PC.
REQ-009 SHALL have i_imem_data  input  INSTR_W  memory read data, valid one cycle after address presented.
REQ-010 SHALL have o_instr  output  INSTR_W  IF/ID instruction.
REQ-011 SHALL have o_opcode  output  4  o_instr top 4 bits, combinational, feeds opcode decoder.
REQ-012 SHALL have o_pc  output  PC_W  address of o_instr.
REQ-013 SHALL have o_valid  output  1  o_instr is a real instruction; 0 = bubble (opcode 0000 is LDA, so downstream gates on o_valid).

Function
REQ-014 SHALL hold state: pc, req_pc, req_valid, IF/ID {instr, pc, valid}, 2-state FSM FILL/RUN.
REQ-015 SHALL in FILL: present pc, IF/ID valid<=0, req_pc<=pc, req_valid<=1, pc<=pc+1, go RUN.
REQ-016 SHALL in RUN, no stall, no branch: IF/ID<={i_imem_data, req_pc, req_valid}; req_pc<=pc; req_valid<=1; pc<=pc+1.
REQ-017 SHALL wrap pc modulo 2^PC_W (all-ones +1 = 0) with no error indication.
REQ-018 SHALL on i_stall=1 and i_branch_taken=0: hold pc, req_pc, req_valid, IF/ID, FSM state; memory is read every cycle so held address re-returns same data.
REQ-019 SHALL on i_branch_taken=1 (any state, priority over i_stall): pc<=i_branch_target, req_valid<=0, IF/ID valid<=0, FSM<=RUN.
REQ-020 SHALL give branch penalty of exactly 2 bubbles: o_valid=0 in cycles T+1, T+2 after branch in cycle T; target instruction with o_valid=1 in T+3 absent stall.
REQ-021 SHALL, on back-to-back branches, honour the latest target; earlier in-flight fetch discarded.
REQ-022 SHALL drive o_instr/o_pc unchanged when squashing (only valid cleared); verification checks o_valid only for bubbles.

Reset
REQ-023 SHALL on i_rst=1 at a clock edge: pc=0, req_pc=0, req_valid=0, o_instr=0, o_pc=0, o_valid=0, FSM=FILL, counters=0.
REQ-024 SHALL give i_rst priority over i_branch_taken and i_stall; reset mid-stall or mid-redirect discards all state.
REQ-025 SHALL deliver instruction at address 0 with o_valid=1 in the third cycle after reset deassertion (FILL, RUN fetch, IF/ID capture).

Configuration
REQ-026 SHALL, with macro FETCH_PERF_CNT_EN defined, add outputs o_fetch_cnt (16) counting cycles IF/ID captures valid=1, and o_redirect_cnt (16) counting accepted branches; both saturate at 0xFFFF, reset to 0.
REQ-027 SHALL, without FETCH_PERF_CNT_EN, omit both ports and counter logic; all other behaviour identical.

Verification
REQ-028 SHALL cover reset then run, ROM word n = 0x1000+n: o_valid=1 from 3rd cycle, o_pc 0,1,2,... o_instr 0x1000,0x1001,...
REQ-029 SHALL cover stall 3 cycles while o_pc=5: o_pc=5, o_instr=0x1005 held 3 cycles, then 6 follows with no gap or duplicate.
REQ-030 SHALL cover branch to 0x40 in cycle T: o_valid=0 in T+1,T+2; T+3 o_pc=0x40, o_instr=0x1040.
REQ-031 SHALL cover branch and stall same cycle, and branches in consecutive cycles to 0x10 then 0x20: only 0x20 stream delivered.
REQ-032 SHALL cover wrap: branch to 0xFE, run: o_pc 0xFE, 0xFF, 0x00 all o_valid=1.
REQ-033 SHALL cover reset asserted during redirect bubble and, with FETCH_PERF_CNT_EN, counter values (10 fetches + 1 branch -> o_fetch_cnt=10, o_redirect_cnt=1) and 0xFFFF saturation.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, one in-flight memory request and the IF/ID register.
// Define FETCH_PERF_CNT_EN to add saturating fetch/redirect performance counters.
module fetch_stage #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_stall,
  input  logic               i_branch_taken,
  input  logic [PC_W-1:0]    i_branch_target,
  output logic [PC_W-1:0]    o_imem_addr,
  input  logic [INSTR_W-1:0] i_imem_data,
  output logic [INSTR_W-1:0] o_instr,
  output logic [3:0]         o_opcode,
  output logic [PC_W-1:0]    o_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]        o_fetch_cnt,
  output logic [15:0]        o_redirect_cnt,
`endif
  output logic               o_valid
);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]         state;
  logic [PC_W-1:0]    pc_p0;
  logic [PC_W-1:0]    req_pc_p0;
  logic               vld_p0;
  logic [INSTR_W-1:0] instr_p1;
  logic [PC_W-1:0]    pc_p1;
  logic               vld_p1;

  // While stalled, keep re-reading the in-flight address so the memory
  // output still holds that word when the stall releases.
  assign o_imem_addr = i_stall ? req_pc_p0 : pc_p0;

  // p0: PC and outstanding request
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_FILL;
      pc_p0     <= '0;
      req_pc_p0 <= '0;
      vld_p0    <= 1'b0;
      instr_p1  <= '0;
      pc_p1     <= '0;
      vld_p1    <= 1'b0;
    end else if (i_branch_taken) begin
      pc_p0  <= i_branch_target;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      state  <= ST_RUN;
    end else if (!i_stall) begin
      if (state == ST_FILL) begin
        vld_p1 <= 1'b0;
        state  <= ST_RUN;
      end else begin
        // p1: IF/ID capture of the word returned for the outstanding request
        instr_p1 <= i_imem_data;
        pc_p1    <= req_pc_p0;
        vld_p1   <= vld_p0;
      end
      req_pc_p0 <= pc_p0;
      vld_p0    <= 1'b1;
      pc_p0     <= pc_p0 + 1'b1;
    end
  end

  assign o_instr  = instr_p1;
  assign o_opcode = instr_p1[INSTR_W-1 -: 4];
  assign o_pc     = pc_p1;
  assign o_valid  = vld_p1;

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  logic capture_vld;
  assign capture_vld = !i_branch_taken && !i_stall && (state == ST_RUN) && vld_p0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_fetch_cnt    <= '0;
      o_redirect_cnt <= '0;
    end else begin
      if (capture_vld)    o_fetch_cnt    <= sat_inc(o_fetch_cnt);
      if (i_branch_taken) o_redirect_cnt <= sat_inc(o_redirect_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: ROM word n = 0x1000+n behind a one-cycle read.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [7:0]  br_tgt = '0;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data = '0;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [7:0]  pc;
  logic        valid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt;
  logic [15:0] redirect_cnt;
`endif

  int total = 0;
  int bad   = 0;

  fetch_stage #(.PC_W(8), .INSTR_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall),
    .i_branch_taken(br), .i_branch_target(br_tgt),
    .o_imem_addr(imem_addr), .i_imem_data(imem_data),
    .o_instr(instr), .o_opcode(opcode), .o_pc(pc),
`ifdef FETCH_PERF_CNT_EN
    .o_fetch_cnt(fetch_cnt), .o_redirect_cnt(redirect_cnt),
`endif
    .o_valid(valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= 16'h1000 + {8'h00, imem_addr};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    total++; if (pc !== 8'h00) begin bad++; $display("FAIL reset_pc: got %h want 00", pc); end
    total++; if (instr !== 16'h0000) begin bad++; $display("FAIL reset_instr: got %h want 0000", instr); end
    rst = 1'b0;
    tick();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL fill_valid: got %b want 0", valid); end
  endtask

  task automatic test_run();
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL run_valid[%0d]: got %b want 1", i, valid); end
      total++; if (pc !== 8'(i)) begin bad++; $display("FAIL run_pc[%0d]: got %h want %h", i, pc, 8'(i)); end
      total++; if (instr !== 16'h1000 + 16'(i)) begin bad++; $display("FAIL run_instr[%0d]: got %h want %h", i, instr, 16'h1000 + 16'(i)); end
      total++; if (opcode !== 4'h1) begin bad++; $display("FAIL run_opcode[%0d]: got %h want 1", i, opcode); end
    end
    total++; if (imem_addr !== 8'h06) begin bad++; $display("FAIL run_addr: got %h want 06", imem_addr); end
  endtask

  task automatic test_stall();
    tick();
    total++; if (pc !== 8'h05) begin bad++; $display("FAIL prestall_pc: got %h want 05", pc); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (pc !== 8'h05 || instr !== 16'h1005 || valid !== 1'b1) begin
        bad++; $display("FAIL stall_hold[%0d]: got pc=%h instr=%h v=%b want 05/1005/1", i, pc, instr, valid);
      end
    end
    stall = 1'b0;
    for (int i = 6; i < 9; i++) begin
      tick();
      total++; if (pc !== 8'(i) || instr !== 16'h1000 + 16'(i) || valid !== 1'b1) begin
        bad++; $display("FAIL post_stall[%0d]: got pc=%h instr=%h v=%b want %h/%h/1", i, pc, instr, valid, 8'(i), 16'h1000 + 16'(i));
      end
    end
  endtask

  task automatic test_branch();
    br = 1'b1; br_tgt = 8'h40;
    tick();
    br = 1'b0;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL br_bubble1: got %b want 0", valid); end
    tick();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL br_bubble2: got %b want 0", valid); end
    tick();
    total++; if (pc !== 8'h40 || instr !== 16'h1040 || valid !== 1'b1) begin
      bad++; $display("FAIL br_target: got pc=%h instr=%h v=%b want 40/1040/1", pc, instr, valid);
    end
    tick();
    total++; if (pc !== 8'h41 || instr !== 16'h1041 || valid !== 1'b1) begin
      bad++; $display("FAIL br_next: got pc=%h instr=%h v=%b want 41/1041/1", pc, instr, valid);
    end
  endtask

  task automatic test_branch_stall();
    br = 1'b1; stall = 1'b1; br_tgt = 8'h30;
    tick();
    br = 1'b0; stall = 1'b0;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL brst_bubble1: got %b want 0", valid); end
    tick();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL brst_bubble2: got %b want 0", valid); end
    tick();
    total++; if (pc !== 8'h30 || instr !== 16'h1030 || valid !== 1'b1) begin
      bad++; $display("FAIL brst_target: got pc=%h instr=%h v=%b want 30/1030/1", pc, instr, valid);
    end
    tick();
    total++; if (pc !== 8'h31 || instr !== 16'h1031 || valid !== 1'b1) begin
      bad++; $display("FAIL brst_next: got pc=%h instr=%h v=%b want 31/1031/1", pc, instr, valid);
    end
  endtask

  task automatic test_back_to_back();
    br = 1'b1; br_tgt = 8'h10;
    tick();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL b2b_bubble1: got %b want 0", valid); end
    br_tgt = 8'h20;
    tick();
    br = 1'b0;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL b2b_bubble2: got %b want 0", valid); end
    tick();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL b2b_bubble3: got %b want 0", valid); end
    tick();
    total++; if (pc !== 8'h20 || instr !== 16'h1020 || valid !== 1'b1) begin
      bad++; $display("FAIL b2b_target: got pc=%h instr=%h v=%b want 20/1020/1", pc, instr, valid);
    end
    tick();
    total++; if (pc !== 8'h21 || instr !== 16'h1021 || valid !== 1'b1) begin
      bad++; $display("FAIL b2b_next: got pc=%h instr=%h v=%b want 21/1021/1", pc, instr, valid);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc;
    br = 1'b1; br_tgt = 8'hFE;
    tick();
    br = 1'b0;
    tick();
    exp_pc = 8'hFE;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (pc !== exp_pc || instr !== 16'h1000 + {8'h00, exp_pc} || valid !== 1'b1) begin
        bad++; $display("FAIL wrap[%0d]: got pc=%h instr=%h v=%b want %h/%h/1", i, pc, instr, valid, exp_pc, 16'h1000 + {8'h00, exp_pc});
      end
      exp_pc = exp_pc + 8'h01;
    end
  endtask

  task automatic test_reset_bubble();
    br = 1'b1; br_tgt = 8'h40;
    tick();
    br = 1'b0;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rstb_bubble: got %b want 0", valid); end
    rst = 1'b1; br = 1'b1; br_tgt = 8'h80; stall = 1'b1;
    tick();
    total++; if (pc !== 8'h00 || instr !== 16'h0000 || valid !== 1'b0) begin
      bad++; $display("FAIL rstb_state: got pc=%h instr=%h v=%b want 00/0000/0", pc, instr, valid);
    end
    rst = 1'b0; br = 1'b0; stall = 1'b0;
    tick();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rstb_fill: got %b want 0", valid); end
    tick();
    total++; if (pc !== 8'h00 || instr !== 16'h1000 || valid !== 1'b1) begin
      bad++; $display("FAIL rstb_first: got pc=%h instr=%h v=%b want 00/1000/1", pc, instr, valid);
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_counters();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (fetch_cnt !== 16'd0 || redirect_cnt !== 16'd0) begin
      bad++; $display("FAIL cnt_reset: got %0d/%0d want 0/0", fetch_cnt, redirect_cnt);
    end
    repeat (11) tick();
    br = 1'b1; br_tgt = 8'h00;
    tick();
    br = 1'b0;
    total++; if (fetch_cnt !== 16'd10) begin bad++; $display("FAIL cnt_fetch: got %0d want 10", fetch_cnt); end
    total++; if (redirect_cnt !== 16'd1) begin bad++; $display("FAIL cnt_redirect: got %0d want 1", redirect_cnt); end
    repeat (66000) tick();
    total++; if (fetch_cnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_sat: got %h want FFFF", fetch_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_run();
    test_stall();
    test_branch();
    test_branch_stall();
    test_back_to_back();
    test_wrap();
    test_reset_bubble();
`ifdef FETCH_PERF_CNT_EN
    test_counters();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
